// File: rtl/ya_fifo_pkg.sv
// Shared definitions for the ya_fifo family: read-mode type and size helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ya_fifo_pkg;

  // Read-mode selector, derived from the FWFT parameter of the top.
  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } rd_mode_e;

  // Supported range of ADDR_SIZE.
  localparam int ADDR_SIZE_MIN = 2;
  localparam int ADDR_SIZE_MAX = 16;

  // Number of words held by a FIFO with the given address width.
  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/ya_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with reset-to-zero output.
// Latency: read data valid one cycle after re.
// Backpressure: none; the caller guarantees address validity.
module ya_fifo_ram import ya_fifo_pkg::*; #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [0:depth_of(ADDR_SIZE)-1];

  // Storage array; contents are deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register; reset so the FIFO output starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ya_fifo_prog.sv
// Programmable FIFO: standard or FWFT read, fill count, runtime almost-full/empty thresholds.
// Latency: standard write->not_empty 1 cycle, read data 1 cycle; FWFT write->head valid 2 cycles.
// Backpressure: writes refused while full, reads refused while empty; sticky error flags with YA_FIFO_ERR_FLAGS_EN.
module ya_fifo_prog import ya_fifo_pkg::*; #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8,
  parameter int FWFT      = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_we,
  output logic                 o_is_not_full,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_re,
  output logic                 o_is_not_empty,
  output logic [WORD_SIZE-1:0] o_data,
  output logic [ADDR_SIZE:0]   o_count,
  input  logic [ADDR_SIZE:0]   i_af_thresh,
  input  logic [ADDR_SIZE:0]   i_ae_thresh,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int             PW    = ptr_width(ADDR_SIZE);
  localparam logic [PW-1:0]  DEPTH = PW'(depth_of(ADDR_SIZE));
  localparam rd_mode_e       MODE  = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_q;      // write pointer delayed one cycle, FWFT preload view
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic          not_empty_q;   // in FWFT this doubles as the head-word valid bit
  logic          not_empty_nxt;
  logic          wr_acc;
  logic          rd_acc;
  logic          ram_re;
  logic          mem_has;

  // Handshake, pointer advance and preload decisions.
  always_comb begin
    wr_acc        = i_we && o_is_not_full;
    wr_ptr_nxt    = wr_ptr + PW'(wr_acc);
    rd_acc        = i_re && not_empty_q;
    mem_has       = 1'b0;
    ram_re        = 1'b0;
    rd_ptr_nxt    = rd_ptr;
    not_empty_nxt = 1'b0;
    if (MODE == RD_FWFT) begin
      // RAM words become fetchable one cycle after being written, giving the
      // two-cycle write-to-head latency; a pop refetches in the same edge.
      mem_has       = (wr_ptr_q != rd_ptr);
      ram_re        = mem_has && (!not_empty_q || rd_acc);
      rd_ptr_nxt    = rd_ptr + PW'(ram_re);
      not_empty_nxt = ram_re || (not_empty_q && !rd_acc);
    end else begin
      ram_re        = rd_acc;
      rd_ptr_nxt    = rd_ptr + PW'(rd_acc);
      not_empty_nxt = (wr_ptr_nxt != rd_ptr_nxt);
    end
  end

  // Pointer and read-side state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_ptr_q    <= '0;
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr_q    <= wr_ptr;
      not_empty_q <= not_empty_nxt;
    end
  end

  // Fill level and flags; in FWFT the head register holds one word beyond the RAM.
  always_comb begin
    o_count = wr_ptr - rd_ptr;
    if (MODE == RD_FWFT) begin
      o_count = wr_ptr - rd_ptr + PW'(not_empty_q);
    end
    o_is_not_full  = (o_count != DEPTH);
    o_is_not_empty = not_empty_q;
    o_almost_full  = (o_count >= i_af_thresh);
    o_almost_empty = (o_count <= i_ae_thresh);
  end

  ya_fifo_ram #(
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_ram (
    .clk   (i_clk),
    .reset (i_reset),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_SIZE-1:0]),
    .wdata (i_data),
    .re    (ram_re),
    .raddr (rd_ptr[ADDR_SIZE-1:0]),
    .rdata (o_data)
  );

`ifdef YA_FIFO_ERR_FLAGS_EN
  // Sticky capture of refused writes and reads; cleared only by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_we && !o_is_not_full) begin
        o_overflow <= 1'b1;
      end
      if (i_re && !o_is_not_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ya_fifo_prog.sv
// Directed bench for ya_fifo_prog: one standard-mode and one FWFT instance, DEPTH=4.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Error-flag expectations follow whether YA_FIFO_ERR_FLAGS_EN is defined.
module tb_ya_fifo_prog;

`ifdef YA_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] af_th;
  logic [2:0] ae_th;

  logic       s_we, s_re, s_nf, s_ne, s_af, s_ae, s_ovf, s_unf;
  logic [7:0] s_din, s_dout;
  logic [2:0] s_cnt;

  logic       f_we, f_re, f_nf, f_ne, f_af, f_ae, f_ovf, f_unf;
  logic [7:0] f_din, f_dout;
  logic [2:0] f_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ya_fifo_prog #(.ADDR_SIZE(2), .WORD_SIZE(8), .FWFT(0)) dut_std (
    .i_clk(clk), .i_reset(rst), .i_we(s_we), .o_is_not_full(s_nf), .i_data(s_din),
    .i_re(s_re), .o_is_not_empty(s_ne), .o_data(s_dout), .o_count(s_cnt),
    .i_af_thresh(af_th), .i_ae_thresh(ae_th), .o_almost_full(s_af),
    .o_almost_empty(s_ae), .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  ya_fifo_prog #(.ADDR_SIZE(2), .WORD_SIZE(8), .FWFT(1)) dut_fwft (
    .i_clk(clk), .i_reset(rst), .i_we(f_we), .o_is_not_full(f_nf), .i_data(f_din),
    .i_re(f_re), .o_is_not_empty(f_ne), .o_data(f_dout), .o_count(f_cnt),
    .i_af_thresh(af_th), .i_ae_thresh(ae_th), .o_almost_full(f_af),
    .o_almost_empty(f_ae), .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_tests++; if (s_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", s_cnt); end
    n_tests++; if (s_nf !== 1'b1) begin n_fail++; $display("FAIL reset_not_full: got %b expected 1", s_nf); end
    n_tests++; if (s_ne !== 1'b0) begin n_fail++; $display("FAIL reset_not_empty: got %b expected 0", s_ne); end
    n_tests++; if (s_dout !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", s_dout); end
    n_tests++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", {s_ovf, s_unf}); end
    n_tests++; if ({s_af, s_ae} !== 2'b01) begin n_fail++; $display("FAIL reset_almost: got %b expected 01", {s_af, s_ae}); end
    n_tests++; if ({f_ne, f_nf, f_cnt} !== 5'b01000) begin n_fail++; $display("FAIL reset_fwft: got %b expected 01000", {f_ne, f_nf, f_cnt}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill;
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1; s_din = words[i];
      tick();
      n_tests++; if (s_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, s_cnt, i + 1); end
      n_tests++; if (s_af !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, s_af, (i + 1 >= 3)); end
      n_tests++; if (s_ae !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, s_ae, (i + 1 <= 1)); end
      n_tests++; if (s_ne !== 1'b1) begin n_fail++; $display("FAIL fill_not_empty[%0d]: got %b expected 1", i, s_ne); end
      n_tests++; if (s_nf !== (i < 3)) begin n_fail++; $display("FAIL fill_not_full[%0d]: got %b expected %b", i, s_nf, (i < 3)); end
    end
    n_tests++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_before: got %b expected 0", s_ovf); end
    s_din = 8'h55;
    tick();
    s_we = 1'b0;
    n_tests++; if (s_cnt !== 3'd4) begin n_fail++; $display("FAIL overfill_count: got %0d expected 4", s_cnt); end
    n_tests++; if (s_ovf !== ERR_EN) begin n_fail++; $display("FAIL overfill_ovf: got %b expected %b", s_ovf, ERR_EN); end
  endtask

  task automatic test_std_read;
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    s_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (s_dout !== words[i]) begin n_fail++; $display("FAIL std_read_data[%0d]: got %h expected %h", i, s_dout, words[i]); end
      n_tests++; if (s_cnt !== 3'(3 - i)) begin n_fail++; $display("FAIL std_read_count[%0d]: got %0d expected %0d", i, s_cnt, 3 - i); end
    end
    n_tests++; if (s_ne !== 1'b0) begin n_fail++; $display("FAIL std_drained_not_empty: got %b expected 0", s_ne); end
    n_tests++; if (s_unf !== 1'b0) begin n_fail++; $display("FAIL std_unf_before: got %b expected 0", s_unf); end
    tick();
    s_re = 1'b0;
    n_tests++; if (s_unf !== ERR_EN) begin n_fail++; $display("FAIL std_underflow: got %b expected %b", s_unf, ERR_EN); end
    n_tests++; if (s_dout !== 8'h44) begin n_fail++; $display("FAIL std_underflow_hold: got %h expected 44", s_dout); end
    n_tests++; if (s_cnt !== 3'd0) begin n_fail++; $display("FAIL std_underflow_count: got %0d expected 0", s_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [$];
    logic [7:0] exp;
    for (int i = 1; i <= 4; i++) begin
      s_we = 1'b1; s_din = 8'(i);
      tick();
    end
    s_we = 1'b1; s_re = 1'b1; s_din = 8'h99;
    tick();
    n_tests++; if (s_cnt !== 3'd3) begin n_fail++; $display("FAIL full_rw_count: got %0d expected 3", s_cnt); end
    n_tests++; if (s_dout !== 8'h01) begin n_fail++; $display("FAIL full_rw_data: got %h expected 01", s_dout); end
    s_we = 1'b0;
    tick();
    n_tests++; if (s_dout !== 8'h02) begin n_fail++; $display("FAIL full_rw_second: got %h expected 02", s_dout); end
    q.push_back(8'h03); q.push_back(8'h04);
    s_we = 1'b1; s_re = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_din = 8'hC0 + 8'(i);
      tick();
      exp = q.pop_front();
      q.push_back(8'hC0 + 8'(i));
      n_tests++; if (s_dout !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, s_dout, exp); end
      n_tests++; if (s_cnt !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, s_cnt); end
    end
    s_we = 1'b0; s_re = 1'b0;
  endtask

  task automatic test_async_reset;
    s_we = 1'b1; s_din = 8'h5A;
    tick();
    s_we = 1'b0;
    n_tests++; if (s_cnt !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", s_cnt); end
    #3;
    rst = 1'b1;
    #1;
    n_tests++; if (s_cnt !== 3'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", s_cnt); end
    n_tests++; if ({s_nf, s_ne} !== 2'b10) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 10", {s_nf, s_ne}); end
    n_tests++; if (s_dout !== 8'h00) begin n_fail++; $display("FAIL async_reset_data: got %h expected 00", s_dout); end
    n_tests++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL async_reset_err: got %b expected 00", {s_ovf, s_unf}); end
    #1;
    rst = 1'b0;
    tick();
    s_we = 1'b1; s_din = 8'h77;
    tick();
    s_we = 1'b0;
    n_tests++; if (s_cnt !== 3'd1) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 1", s_cnt); end
    s_re = 1'b1;
    tick();
    s_re = 1'b0;
    n_tests++; if (s_dout !== 8'h77) begin n_fail++; $display("FAIL post_reset_data: got %h expected 77", s_dout); end
  endtask

  task automatic test_fwft;
    logic [7:0] words [3];
    words[0] = 8'hB1; words[1] = 8'hB2; words[2] = 8'hB3;
    f_we = 1'b1; f_din = 8'hA5;
    tick();
    f_we = 1'b0;
    n_tests++; if ({f_ne, f_cnt} !== 4'b0001) begin n_fail++; $display("FAIL fwft_edge0: got %b expected 0001", {f_ne, f_cnt}); end
    tick();
    n_tests++; if (f_ne !== 1'b0) begin n_fail++; $display("FAIL fwft_edge1_not_empty: got %b expected 0", f_ne); end
    tick();
    n_tests++; if (f_ne !== 1'b1) begin n_fail++; $display("FAIL fwft_edge2_not_empty: got %b expected 1", f_ne); end
    n_tests++; if (f_dout !== 8'hA5) begin n_fail++; $display("FAIL fwft_head: got %h expected a5", f_dout); end
    n_tests++; if (f_cnt !== 3'd1) begin n_fail++; $display("FAIL fwft_head_count: got %0d expected 1", f_cnt); end
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    n_tests++; if ({f_ne, f_cnt} !== 4'b0000) begin n_fail++; $display("FAIL fwft_pop: got %b expected 0000", {f_ne, f_cnt}); end
    for (int i = 0; i < 3; i++) begin
      f_we = 1'b1; f_din = words[i];
      tick();
    end
    f_we = 1'b0;
    tick(); tick();
    n_tests++; if ({f_ne, f_cnt} !== 4'b1011) begin n_fail++; $display("FAIL fwft_fill3: got %b expected 1011", {f_ne, f_cnt}); end
    n_tests++; if (f_dout !== 8'hB1) begin n_fail++; $display("FAIL fwft_fill3_head: got %h expected b1", f_dout); end
    f_re = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_tests++; if (f_dout !== words[i] || f_ne !== 1'b1) begin n_fail++; $display("FAIL fwft_stream[%0d]: got %h/%b expected %h/1", i, f_dout, f_ne, words[i]); end
    end
    tick();
    n_tests++; if ({f_ne, f_cnt} !== 4'b0000) begin n_fail++; $display("FAIL fwft_stream_end: got %b expected 0000", {f_ne, f_cnt}); end
    n_tests++; if (f_unf !== 1'b0) begin n_fail++; $display("FAIL fwft_unf_before: got %b expected 0", f_unf); end
    tick();
    f_re = 1'b0;
    n_tests++; if (f_unf !== ERR_EN) begin n_fail++; $display("FAIL fwft_underflow: got %b expected %b", f_unf, ERR_EN); end
  endtask

  task automatic test_thresholds;
    s_we = 1'b1; s_din = 8'hE1;
    tick();
    s_we = 1'b0;
    af_th = 3'd0; ae_th = 3'd5;
    #1;
    n_tests++; if ({s_af, s_ae} !== 2'b11) begin n_fail++; $display("FAIL thresh_extreme: got %b expected 11", {s_af, s_ae}); end
    af_th = 3'd5; ae_th = 3'd0;
    #1;
    n_tests++; if ({s_af, s_ae} !== 2'b00) begin n_fail++; $display("FAIL thresh_out_of_range: got %b expected 00", {s_af, s_ae}); end
    af_th = 3'd3; ae_th = 3'd1;
  endtask

  initial begin
    rst = 1'b1; af_th = 3'd3; ae_th = 3'd1;
    s_we = 1'b0; s_re = 1'b0; s_din = 8'h00;
    f_we = 1'b0; f_re = 1'b0; f_din = 8'h00;
    test_reset();
    test_fill();
    test_std_read();
    test_back_to_back();
    test_async_reset();
    test_fwft();
    test_thresholds();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ya_fifo_prog.md
Name: ya_fifo_prog

Overview:
Parametrised successor to the standard and FWFT FIFO instances. A single module selects read mode by parameter and adds capabilities the earlier FIFOs lack:
- live fill count
- runtime-programmable almost-full and almost-empty thresholds
- optional sticky overflow/underflow error flags

It drops in wherever the standard or FWFT FIFO is used today, with the same write/read handshake.

Parameters:
ADDR_SIZE, 10, log2 of capacity; DEPTH = 2**ADDR_SIZE words (valid range 2..16)
WORD_SIZE, 8, data width in bits
FWFT, 0, 0 = standard read (data one cycle after accepted read); 1 = first-word-fall-through

Ports:
i_clk  in  1  single clock; all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_we  in  1  write request
o_is_not_full  out  1  high when a write will be accepted
i_data  in  WORD_SIZE  write data
i_re  in  1  read request (FWFT: pop/acknowledge)
o_is_not_empty  out  1  high when a read will be accepted (FWFT: o_data holds valid head word)
o_data  out  WORD_SIZE  read data
o_count  out  ADDR_SIZE+1  words currently held, 0..DEPTH
i_af_thresh  in  ADDR_SIZE+1  almost-full threshold
i_ae_thresh  in  ADDR_SIZE+1  almost-empty threshold
o_almost_full  out  1  o_count >= i_af_thresh
o_almost_empty  out  1  o_count <= i_ae_thresh
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset values (asynchronous): write/read pointers 0, o_count 0, o_is_not_full 1, o_is_not_empty 0, o_data 0, o_overflow 0, o_underflow 0. o_almost_empty and o_almost_full follow the threshold compares immediately.
- Pointers are ADDR_SIZE+1 bits and wrap modulo 2*DEPTH. The MSB distinguishes full from empty.
- Write accepted iff i_we && o_is_not_full; the word is stored at the write pointer on that edge.
- Read accepted iff i_re && o_is_not_empty.
- Rejected requests leave all state unchanged apart from the error flags.
- o_count changes per edge by +1 (write only), -1 (read only), or 0 (both or neither). It counts every word held, including the FWFT output register.
- o_is_not_full = (o_count != DEPTH). o_is_not_empty is registered; the timing per mode is below.
- Standard mode (FWFT=0):
  - o_is_not_empty = (o_count != 0).
  - o_data updates on the edge of an accepted read; it is valid from the next cycle and holds until the next accepted read.
  - Write-to-not_empty latency: 1 cycle.
- FWFT mode: an internal output-valid register preloads the head word from memory.
  - Write into an empty FIFO: o_is_not_empty rises 2 cycles after the write edge, with o_data already valid.
  - Accepted read: the next word appears the following cycle with no bubble when memory is non-empty. Otherwise o_is_not_empty drops.
- Simultaneous write and read:
  - When full: the write is rejected (flag is low) and the read is accepted.
  - When empty (standard), or with no valid head (FWFT): the read is rejected and the write is accepted.
- Thresholds are sampled combinationally every cycle and may change at any time. Threshold 0 makes almost_full constantly 1; a threshold > DEPTH makes it constantly 0.
- Error flags are set by i_we && !o_is_not_full (overflow) or i_re && !o_is_not_empty (underflow). They clear only on reset.
- Reset mid-operation discards all contents; the RAM contents need no clearing.

Optional Feature:
YA_FIFO_ERR_FLAGS_EN:
- Defined: o_overflow and o_underflow behave as above.
- Undefined: both ports are tied to 0 and their registers are not synthesised.
- Ports exist in both builds.

Decomposition:
- Package ya_fifo_pkg holds the read-mode enumerated type (standard, fwft), the DEPTH derivation, and a pointer-width helper function.
- Sub-module ya_fifo_ram: simple dual-port RAM with synchronous write and registered read, parameterised by ADDR_SIZE/WORD_SIZE.
- Pointer, count, flag and FWFT preload logic stay in the top module.

Test Plan (ADDR_SIZE=2 → DEPTH=4, WORD_SIZE=8, thresholds af=3, ae=1):
- Reset then write 0x11,0x22,0x33,0x44 → o_count 1,2,3,4; o_almost_full rises at count 3; o_is_not_full low after 4th write; 5th write 0x55 rejected, o_overflow=1 (macro defined), o_count stays 4.
- FWFT=0, read four times from full → o_data 0x11,0x22,0x33,0x44, each one cycle after its read; o_is_not_empty low after 4th; extra read sets o_underflow, o_data holds 0x44.
- FWFT=1, write 0xA5 into empty FIFO → o_is_not_empty high and o_data=0xA5 two cycles later with no read; i_re for one cycle → o_is_not_empty low next cycle, o_count 0.
- Full FIFO, i_we and i_re together → read accepted, write rejected, o_count 3. Then at count 2, simultaneous write/read for 10 cycles → o_count stays 2, data order preserved across pointer wrap.
- Assert i_reset asynchronously mid-stream at count 3 → all outputs at reset values before the next clock edge; subsequent write 0x77 reads back as 0x77.
- Build without YA_FIFO_ERR_FLAGS_EN; overfill and overdrain → o_overflow and o_underflow remain 0.
